// File: rtl/demux142_pkg.sv
// Shared constants and helpers for the demux142 1-to-4 stream demultiplexer.
// Holds default data width and per-channel FIFO depth, channel index codes,
// and the occupancy-counter width helper used by the channel FIFOs.
package demux142_pkg;

    localparam int DEMUX_W     = 2;
    localparam int DEMUX_DEPTH = 2;

    localparam logic [1:0] CH0 = 2'b00;
    localparam logic [1:0] CH1 = 2'b01;
    localparam logic [1:0] CH2 = 2'b10;
    localparam logic [1:0] CH3 = 2'b11;

    // Occupancy must hold 0..DEPTH inclusive, hence one bit more than the pointer.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/demux142_chan_fifo.sv
// Purpose: synchronous per-channel FIFO with registered head output.
// Latency: word pushed at edge N is on dout (empty=0) after edge N.
// Backpressure: push ignored while full; pop ignored while empty.
// Ports: clk, rst (async active-high), push/din/full (write side),
//        pop/dout/empty (read side).
module demux142_chan_fifo
    import demux142_pkg::*;
#(
    parameter int W     = DEMUX_W,
    parameter int DEPTH = DEMUX_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = occ_width(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] occ;

    logic do_push;
    logic do_pop;

    assign full  = (occ == OW'(DEPTH));
    assign empty = (occ == '0);
    assign dout  = mem[rd_ptr];

    // Full blocks push even when a pop happens in the same cycle, so the
    // write side never depends on the consumer's ready.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/demux142.sv
// Purpose: registered 1-to-4 stream demux; in_sel steers each word into one of four FIFOs.
// Latency: accepted word visible on yk one cycle later; earliest pop the following edge.
// Backpressure: in_ready = !full of selected channel only; a stalled channel blocks only itself.
// Ports: clk, rst (async active-high); in_data/in_sel/in_valid/in_ready input stream;
//        y0..y3 heads, y_valid/y_ready per-channel handshake; busy = any channel non-empty.
module demux142
    import demux142_pkg::*;
#(
    parameter int W     = DEMUX_W,
    parameter int DEPTH = DEMUX_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic [3:0]   y_valid,
    input  logic [3:0]   y_ready,
    output logic         busy
);

    logic [3:0]   full;
    logic [3:0]   empty;
    logic [3:0]   push;
    logic [W-1:0] dout [4];

    // Registered occupancy only: no path from y_ready into in_ready.
    assign in_ready = !full[in_sel];

    always_comb begin
        push = 4'b0000;
        if (in_valid && in_ready) begin
            case (in_sel)
                CH0:     push[0] = 1'b1;
                CH1:     push[1] = 1'b1;
                CH2:     push[2] = 1'b1;
                CH3:     push[3] = 1'b1;
                default: push    = 4'b0000;
            endcase
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_chan
        demux142_chan_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[k]),
            .din   (in_data),
            .full  (full[k]),
            .pop   (y_ready[k]),
            .dout  (dout[k]),
            .empty (empty[k])
        );
    end

    assign y_valid = ~empty;
    assign y0      = dout[0];
    assign y1      = dout[1];
    assign y2      = dout[2];
    assign y3      = dout[3];
    assign busy    = |y_valid;

endmodule

// File: tb/tb_demux142.sv
module tb_demux142;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] y0, y1, y2, y3;
    logic [3:0] y_valid;
    logic [3:0] y_ready;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux142 dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .busy     (busy)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'b00; in_data = 2'b00; y_ready = 4'b0000;
        tick(); tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (y_valid !== 4'b0000) begin n_err++; $display("FAIL reset_yvalid: got %b want 0000", y_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_inready: got %b want 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        tick();
        // Put two words into ch2, then reset asynchronously mid-cycle.
        in_valid = 1'b1; in_sel = 2'b10; in_data = 2'b01;
        tick();
        in_data = 2'b10;
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (y_valid !== 4'b0100 || y2 !== 2'b01) begin n_err++; $display("FAIL pre_reset_ch2: got yv=%b y2=%b want 0100/01", y_valid, y2); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL pre_reset_full: got %b want 0", in_ready); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (y_valid !== 4'b0000) begin n_err++; $display("FAIL async_reset_yvalid: got %b want 0000", y_valid); end
        n_cmp++; if (y2 !== 2'b00) begin n_err++; $display("FAIL async_reset_y2: got %b want 00", y2); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL async_reset_inready: got %b want 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_reset_busy: got %b want 0", busy); end
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_routing;
        logic [1:0] sels  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [1:0] datas [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
        logic [3:0] ch_vld;
        logic [1:0] ch_dat;
        y_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = sels[i]; in_data = datas[i];
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL route_inready_%0d: got %b want 1", i, in_ready); end
            tick();
            in_valid = 1'b0;
            #1;
            ch_vld = 4'b0001 << i;
            case (i)
                0: ch_dat = y0;
                1: ch_dat = y1;
                2: ch_dat = y2;
                default: ch_dat = y3;
            endcase
            n_cmp++; if (y_valid !== ch_vld || ch_dat !== datas[i]) begin
                n_err++; $display("FAIL route_out_%0d: got yv=%b y=%b want %b/%b", i, y_valid, ch_dat, ch_vld, datas[i]);
            end
        end
        tick();
        n_cmp++; if (y_valid !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL route_drained: got yv=%b busy=%b want 0000/0", y_valid, busy); end
    endtask

    task automatic test_fill_backpressure;
        y_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'b01; in_data = 2'b11;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_first_rdy: got %b want 1", in_ready); end
        tick();
        in_data = 2'b10;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_second_rdy: got %b want 1", in_ready); end
        tick();
        in_data = 2'b01;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_third_blocked: got %b want 0", in_ready); end
        tick();
        n_cmp++; if (y1 !== 2'b11 || y_valid !== 4'b0010) begin n_err++; $display("FAIL fill_head: got y1=%b yv=%b want 11/0010", y1, y_valid); end
        y_ready = 4'b0010;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_no_passthru: got %b want 0", in_ready); end
        tick();
        n_cmp++; if (y1 !== 2'b10 || in_ready !== 1'b1) begin n_err++; $display("FAIL fill_after_pop: got y1=%b rdy=%b want 10/1", y1, in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (y1 !== 2'b01 || y_valid !== 4'b0010) begin n_err++; $display("FAIL fill_third_out: got y1=%b yv=%b want 01/0010", y1, y_valid); end
        tick();
        n_cmp++; if (y_valid !== 4'b0000) begin n_err++; $display("FAIL fill_drained: got %b want 0000", y_valid); end
        y_ready = 4'b0000;
    endtask

    task automatic test_isolation;
        logic [1:0] d;
        y_ready = 4'b1000;
        in_valid = 1'b1; in_sel = 2'b00; in_data = 2'b10;
        tick();
        in_data = 2'b11;
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                in_sel = 2'b00; in_data = 2'b01;
                #1;
                n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL iso_ch0_blocked_%0d: got %b want 0", i, in_ready); end
                tick();
            end else begin
                d = 2'(i);
                in_sel = 2'b11; in_data = d;
                #1;
                n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL iso_ch3_ready_%0d: got %b want 1", i, in_ready); end
                tick();
                n_cmp++; if (y_valid[3] !== 1'b1 || y3 !== d) begin n_err++; $display("FAIL iso_ch3_out_%0d: got v=%b y3=%b want 1/%b", i, y_valid[3], y3, d); end
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (y_valid !== 4'b0001 || y0 !== 2'b10) begin n_err++; $display("FAIL iso_ch0_kept: got yv=%b y0=%b want 0001/10", y_valid, y0); end
        y_ready = 4'b0001;
        tick();
        n_cmp++; if (y0 !== 2'b11) begin n_err++; $display("FAIL iso_ch0_second: got %b want 11", y0); end
        tick();
        n_cmp++; if (y_valid !== 4'b0000) begin n_err++; $display("FAIL iso_drained: got %b want 0000", y_valid); end
        y_ready = 4'b0000;
    endtask

    task automatic test_simul_push_pop;
        y_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'b10; in_data = 2'b10;
        tick();
        in_data = 2'b11; y_ready = 4'b0100;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || y2 !== 2'b10) begin n_err++; $display("FAIL pp_before: got rdy=%b y2=%b want 1/10", in_ready, y2); end
        tick();
        in_valid = 1'b0; y_ready = 4'b0000;
        #1;
        n_cmp++; if (y2 !== 2'b11 || y_valid !== 4'b0100) begin n_err++; $display("FAIL pp_after: got y2=%b yv=%b want 11/0100", y2, y_valid); end
        y_ready = 4'b0100;
        tick();
        y_ready = 4'b0000;
        n_cmp++; if (y_valid !== 4'b0000) begin n_err++; $display("FAIL pp_occ_one: got %b want 0000", y_valid); end
    endtask

    task automatic test_wrap;
        logic [1:0] q [$];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic exp_rdy;
        logic [1:0] exp_d;
        in_sel = 2'b01;
        while (got < 9 && cyc < 300) begin
            in_valid = (sent < 9);
            in_data = 2'(sent % 4);
            y_ready = {2'b00, 1'($urandom_range(0, 1)), 1'b0};
            #1;
            exp_rdy = (q.size() < 2);
            n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL wrap_rdy_c%0d: got %b want %b", cyc, in_ready, exp_rdy); end
            if (q.size() > 0) begin
                exp_d = q[0];
                n_cmp++; if (y_valid[1] !== 1'b1 || y1 !== exp_d) begin n_err++; $display("FAIL wrap_head_c%0d: got v=%b y1=%b want 1/%b", cyc, y_valid[1], y1, exp_d); end
                if (y_ready[1]) begin
                    void'(q.pop_front());
                    got++;
                end
            end
            if (in_valid && exp_rdy) begin
                q.push_back(in_data);
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0; y_ready = 4'b0000;
        n_cmp++; if (got !== 9) begin n_err++; $display("FAIL wrap_timeout: got %0d words want 9", got); end
        #1;
        n_cmp++; if (y_valid !== 4'b0000) begin n_err++; $display("FAIL wrap_drained: got %b want 0000", y_valid); end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_fill_backpressure();
        test_isolation();
        test_simul_push_pop();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
